// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants, FSM state encoding and parity helper for the FIFO-fed UART transmitter.
package uart_tx_fifo_pkg;

  localparam int UART_PARITY_NONE          = 0;
  localparam int UART_PARITY_ODD           = 1;
  localparam int UART_PARITY_EVEN          = 2;
  localparam int UART_CLKS_PER_BIT_115200  = 1085;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Payload is zero-extended to 9 bits; the extra zeros do not change the XOR.
  function automatic logic calc_parity(input int mode, input logic [8:0] d);
    logic p;
    p = 1'b0;
    case (mode)
      UART_PARITY_ODD:  p = ~^d;
      UART_PARITY_EVEN: p = ^d;
      default:          p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational head read; pushes when full and pops when empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable width/parity/stop bits fed from an internal FIFO.
// Handshake: a word is taken on any rising edge where i_valid && o_ready; o_ready is simply not-full.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = UART_PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_active,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  tx_state_t            state, state_d;
  logic [TW-1:0]        timer, timer_d;
  logic [3:0]           bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 par, par_d;
  logic                 tx_now;
  logic                 bit_done;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] head;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk (sysclk),
    .rst    (rst),
    .push   (i_valid),
    .pop    (pop),
    .din    (i_data),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (o_fifo_count)
  );

  assign o_ready  = !full;
  assign o_busy   = (state != ST_IDLE);
  assign o_active = i_en | o_busy;
  assign bit_done = (timer == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      o_tx    <= 1'b1;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
      par     <= par_d;
      o_tx    <= tx_now;
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = '0;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    par_d     = par;
    pop       = 1'b0;
    tx_now    = 1'b1;
    if (state != ST_IDLE) timer_d = bit_done ? '0 : timer + 1'b1;

    case (state)
      ST_IDLE: begin
        if (i_en && !empty) begin
          pop       = 1'b1;
          shift_d   = head;
          par_d     = calc_parity(PARITY, 9'(head));
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        tx_now = 1'b0;
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_now = shift[0];
        if (bit_done) begin
          shift_d = shift >> 1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != UART_PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        tx_now = par;
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (bit_done) begin
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (i_en && !empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = calc_parity(PARITY, 9'(head));
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
